// File: rtl/cache_mem_fill.sv
// Memory-side block mover for the cache controller: writes back dirty blocks and fills missed blocks.
// Latency: writeback request to rdy is 10 cycles; fill request to rdy is 10 cycles plus the memory read latency.
// Backpressure: none; memory takes one access per cycle, and requests are sampled only in IDLE.
// Optional build macro CACHE_CRITICAL_WORD_FIRST_EN: fills start at the missed word and wrap modulo the block.
module cache_mem_fill #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cache_we,
    output logic [2:0]        cache_off,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              rdy,
    output logic              busy
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int CNT_W  = OFF_W + 1;
    localparam int BASE_W = ADDR_W - OFF_W - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BASE_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_iss_cnt;
    logic [CNT_W-1:0]    r_rcv_cnt;
    logic [OFF_W-1:0]    w_iss_off;
    logic [OFF_W-1:0]    w_rcv_off;
    logic                w_issue;
    logic                w_unused;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]    r_start;

    // Fill offsets rotate from the missed word so it lands in the cache first.
    assign w_iss_off = r_start + r_iss_cnt[OFF_W-1:0];
    assign w_rcv_off = r_start + r_rcv_cnt[OFF_W-1:0];

    // Latch the critical word offset when a fill is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= '0;
        end else if (r_state == S_IDLE && !wb_req && miss_req) begin
            r_start <= miss_addr[OFF_W:1];
        end
    end
`else
    assign w_iss_off = r_iss_cnt[OFF_W-1:0];
    assign w_rcv_off = r_rcv_cnt[OFF_W-1:0];
`endif

    // Byte bits of the request addresses and the rcv counter MSB are never needed.
    assign w_unused = &{1'b0, wb_addr[OFF_W:0], miss_addr[OFF_W:0], r_rcv_cnt[OFF_W]};

    // Fill reads stop once all words are issued; counter MSB keeps the 9th issue from happening.
    assign w_issue = (r_state == S_FILL) && (r_iss_cnt < CNT_W'(WORDS));
    assign busy    = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; every output idles at zero outside its active state.
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        cache_we    = 1'b0;
        cache_off   = '0;
        cache_wdata = '0;
        rdy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb_req) begin
                    w_state_nxt = S_WB;
                end else if (miss_req) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_WB: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {r_base, r_iss_cnt[OFF_W-1:0], 1'b0};
                cache_off = r_iss_cnt[OFF_W-1:0];
                mem_wdata = cache_rdata;
                if (r_iss_cnt == CNT_W'(WORDS - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FILL: begin
                if (w_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = {r_base, w_iss_off, 1'b0};
                end
                if (mem_data_valid) begin
                    cache_we    = 1'b1;
                    cache_off   = w_rcv_off;
                    cache_wdata = mem_rdata;
                    if (r_rcv_cnt == CNT_W'(WORDS - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rdy         = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Base address latch and issue/return counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wb_req) begin
                        r_base    <= wb_addr[ADDR_W-1:OFF_W+1];
                        r_iss_cnt <= '0;
                    end else if (miss_req) begin
                        r_base    <= miss_addr[ADDR_W-1:OFF_W+1];
                        r_iss_cnt <= '0;
                        r_rcv_cnt <= '0;
                    end
                end
                S_WB: begin
                    r_iss_cnt <= r_iss_cnt + 1'b1;
                end
                S_FILL: begin
                    if (w_issue) begin
                        r_iss_cnt <= r_iss_cnt + 1'b1;
                    end
                    if (mem_data_valid) begin
                        r_rcv_cnt <= r_rcv_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_fill.sv
// Directed bench for cache_mem_fill: fills, writebacks, priority, level requests, reset abort.
// Drives inputs on the falling edge and samples outputs 1 time unit later.
// Expected addresses, offsets and data are written out per step.
module tb_cache_mem_fill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic        wb_req;
    logic [15:0] miss_addr;
    logic [15:0] wb_addr;
    logic [15:0] cache_rdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cache_we;
    logic [2:0]  cache_off;
    logic [15:0] cache_wdata;
    logic        rdy;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_mem_fill dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_req       (miss_req),
        .wb_req         (wb_req),
        .miss_addr      (miss_addr),
        .wb_addr        (wb_addr),
        .cache_rdata    (cache_rdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .cache_we       (cache_we),
        .cache_off      (cache_off),
        .cache_wdata    (cache_wdata),
        .rdy            (rdy),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        return a[3:1];
`else
        return 3'd0;
`endif
    endfunction

    task automatic check_zero(input string nm);
        check({nm, "_busy"},  busy,        0);
        check({nm, "_en"},    mem_en,      0);
        check({nm, "_wr"},    mem_wr,      0);
        check({nm, "_addr"},  mem_addr,    0);
        check({nm, "_wdat"},  mem_wdata,   0);
        check({nm, "_we"},    cache_we,    0);
        check({nm, "_off"},   cache_off,   0);
        check({nm, "_cwdat"}, cache_wdata, 0);
        check({nm, "_rdy"},   rdy,         0);
    endtask

    // Called at the falling edge of the first FILL cycle; memory returns `lat` cycles after issue.
    task automatic run_fill(input string nm, input logic [15:0] base, input logic [2:0] s,
                            input int lat, input logic [15:0] dbase);
        logic [2:0] off;
        for (int k = 0; k < lat + 8; k++) begin
            mem_data_valid = (k >= lat);
            mem_rdata      = dbase + 16'(k - lat);
            #1;
            check($sformatf("%s_busy[%0d]", nm, k), busy, 1);
            check($sformatf("%s_en[%0d]", nm, k), mem_en, (k < 8));
            if (k < 8) begin
                off = s + 3'(k);
                check($sformatf("%s_addr[%0d]", nm, k), mem_addr, base | {12'h000, off, 1'b0});
                check($sformatf("%s_wr[%0d]", nm, k), mem_wr, 0);
            end
            check($sformatf("%s_we[%0d]", nm, k), cache_we, (k >= lat));
            if (k >= lat) begin
                off = s + 3'(k - lat);
                check($sformatf("%s_off[%0d]", nm, k), cache_off, off);
                check($sformatf("%s_cwdat[%0d]", nm, k), cache_wdata, dbase + 16'(k - lat));
            end
            check($sformatf("%s_rdy[%0d]", nm, k), rdy, 0);
            tick();
        end
        mem_data_valid = 1'b1;
        mem_rdata      = 16'hFFFF;
        #1;
        check({nm, "_done_rdy"},  rdy,      1);
        check({nm, "_done_busy"}, busy,     1);
        check({nm, "_done_we"},   cache_we, 0);
        check({nm, "_done_en"},   mem_en,   0);
        tick();
        mem_data_valid = 1'b0;
        #1;
        check({nm, "_idle_rdy"},  rdy,  0);
        check({nm, "_idle_busy"}, busy, 0);
    endtask

    // Called at the falling edge of the first WB cycle; stray valids are driven throughout.
    task automatic run_wb(input string nm, input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            cache_rdata    = 16'h1000 + 16'(k);
            mem_data_valid = 1'b1;
            #1;
            check($sformatf("%s_busy[%0d]", nm, k), busy, 1);
            check($sformatf("%s_en[%0d]", nm, k), mem_en, 1);
            check($sformatf("%s_wr[%0d]", nm, k), mem_wr, 1);
            check($sformatf("%s_addr[%0d]", nm, k), mem_addr, base + 16'(2 * k));
            check($sformatf("%s_off[%0d]", nm, k), cache_off, k);
            check($sformatf("%s_wdat[%0d]", nm, k), mem_wdata, 16'h1000 + 16'(k));
            check($sformatf("%s_we[%0d]", nm, k), cache_we, 0);
            check($sformatf("%s_rdy[%0d]", nm, k), rdy, 0);
            tick();
        end
        #1;
        check({nm, "_done_rdy"}, rdy,      1);
        check({nm, "_done_en"},  mem_en,   0);
        check({nm, "_done_we"},  cache_we, 0);
        tick();
        mem_data_valid = 1'b0;
        cache_rdata    = 16'h0000;
    endtask

    initial begin
        rst_n          = 1'b0;
        miss_req       = 1'b0;
        wb_req         = 1'b0;
        miss_addr      = 16'h0000;
        wb_addr        = 16'h0000;
        cache_rdata    = 16'h0000;
        mem_rdata      = 16'h0000;
        mem_data_valid = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // In-order fill of 0x1236, latency 4.
        miss_req  = 1'b1;
        miss_addr = 16'h1236;
        #1;
        check("f1_accept_busy", busy, 0);
        tick();
        miss_req = 1'b0;
        run_fill("f1", 16'h1230, start_of(16'h1236), 4, 16'hD000);

        // Writeback of 0xA0F0 (offset bits ignored), then fill requested after rdy.
        wb_req  = 1'b1;
        wb_addr = 16'hA0FE;
        tick();
        run_wb("wb1", 16'hA0F0);
        wb_req    = 1'b0;
        miss_req  = 1'b1;
        miss_addr = 16'h2004;
        #1;
        check("wb1_idle_busy", busy, 0);
        check("wb1_idle_en", mem_en, 0);
        tick();
        miss_req = 1'b0;
        run_fill("f2", 16'h2000, start_of(16'h2004), 1, 16'hC000);

        // Both requests together: writeback wins; level requests not re-taken in DONE.
        wb_req    = 1'b1;
        miss_req  = 1'b1;
        wb_addr   = 16'h4000;
        miss_addr = 16'h5000;
        tick();
        run_wb("pri", 16'h4000);
        wb_req   = 1'b0;
        miss_req = 1'b0;
        #1;
        check("pri_idle_busy", busy, 0);
        tick();
        check("pri_idle2_busy", busy, 0);
        check("pri_idle2_en", mem_en, 0);

        // miss_req held high through DONE: exactly one fill.
        miss_req  = 1'b1;
        miss_addr = 16'h3002;
        tick();
        run_fill("lvl", 16'h3000, start_of(16'h3002), 2, 16'hB000);
        miss_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lvl_after_busy[%0d]", k), busy, 0);
            check($sformatf("lvl_after_en[%0d]", k), mem_en, 0);
        end

        // Reset after 3 returns, then a fresh fill of 0x0040.
        miss_req  = 1'b1;
        miss_addr = 16'h1000;
        tick();
        miss_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_data_valid = (k >= 2);
            mem_rdata      = 16'h9000 + 16'(k);
            #1;
            check($sformatf("rst_pre_we[%0d]", k), cache_we, (k >= 2));
            tick();
        end
        mem_data_valid = 1'b1;
        rst_n          = 1'b0;
        #1;
        check_zero("rst_async");
        tick();
        rst_n = 1'b1;
        #1;
        check_zero("rst_release");
        mem_data_valid = 1'b0;
        miss_req       = 1'b1;
        miss_addr      = 16'h0040;
        tick();
        miss_req = 1'b0;
        run_fill("f3", 16'h0040, start_of(16'h0040), 3, 16'hE000);

        // Fill of 0x123C: critical word first when enabled, otherwise in order.
        miss_req  = 1'b1;
        miss_addr = 16'h123C;
        tick();
        miss_req = 1'b0;
        run_fill("cwf", 16'h1230, start_of(16'h123C), 4, 16'h7000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_fill.md
Name: cache_mem_fill

Overview:
- Memory-side engine downstream of the cache controller FSM.
- Services its miss and writeback states and returns the single-cycle `rdy` completion strobe that the controller waits on.
- On writeback: streams an 8-word dirty block from the cache data array to main memory.
- On miss: streams an 8-word block from pipelined main memory into the cache data array.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width (2-byte words).
- WORDS, 8, words per block; offset field is addr[3:1]; addr[0] is the byte bit and is always 0 on issued addresses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  1  level request: fill block at miss_addr.
- wb_req  in  1  level request: write back dirty block to wb_addr.
- miss_addr  in  ADDR_W  missing address, any offset.
- wb_addr  in  ADDR_W  victim block address; offset bits ignored.
- cache_rdata  in  DATA_W  cache data-array read data at cache_off, combinational, same cycle.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_rdata valid this cycle.
- mem_en  out  1  memory access issue strobe.
- mem_wr  out  1  1 = write, 0 = read; meaningful only when mem_en=1.
- mem_addr  out  ADDR_W  issued word address.
- mem_wdata  out  DATA_W  write data.
- cache_we  out  1  cache data-array write enable.
- cache_off  out  3  word offset for cache data-array read/write.
- cache_wdata  out  DATA_W  fill data into the cache.
- rdy  out  1  one-cycle completion pulse to the cache controller.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset:
  - State = IDLE; counters and latched base address = 0.
  - All outputs = 0.
  - Reset mid-transfer aborts immediately; no further mem_en or cache_we.
- States: IDLE, WB, FILL, DONE. busy = (state != IDLE).
- IDLE:
  - If wb_req: latch base = {wb_addr[15:4], 4'b0}, clear iss_cnt, go to WB.
  - Else if miss_req: latch base = {miss_addr[15:4], 4'b0}, clear iss_cnt and rcv_cnt, go to FILL.
  - wb_req has priority when both are high.
  - mem_data_valid is ignored in IDLE.
- WB:
  - Each cycle: mem_en=1, mem_wr=1, mem_addr = base | {iss_cnt, 1'b0}, cache_off = iss_cnt, mem_wdata = cache_rdata.
  - Memory accepts one write per cycle; there is no back-pressure.
  - After issuing iss_cnt=7, go to DONE. WB lasts exactly 8 cycles.
- FILL:
  - Issue: while iss_cnt < 8, mem_en=1, mem_wr=0, mem_addr = base | {iss_cnt, 1'b0}, iss_cnt++. Reads occupy 8 back-to-back cycles.
  - Return: on each mem_data_valid, cache_we=1, cache_off = rcv_cnt, cache_wdata = mem_rdata, rcv_cnt++.
  - Returns may overlap issue; latency is set by the memory and is arbitrary but ordered.
  - On the valid with rcv_cnt=7, go to DONE.
  - Counters are 4 bits; the issue stop is compared at 8, so there is no wrap to a 9th issue.
- DONE:
  - rdy=1 for exactly one cycle, then IDLE.
  - Requests are not sampled in DONE, so a level request still high from the controller is not re-accepted.
  - After a writeback rdy, the controller drops wb_req and raises miss_req; that is accepted in the following IDLE cycle.
- Requests arriving while busy are ignored until IDLE.
- Stray mem_data_valid in WB or DONE is ignored: no cache_we.
- cache_we and mem_en are never asserted in IDLE or DONE.
- Minimum latency from request to rdy:
  - WB: 10 cycles (1 IDLE accept + 8 WB + 1 DONE).
  - FILL: 10 + memory read latency.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - FILL starts at s = miss_addr[3:1], latched on accept.
  - Issued and written offsets are (s + cnt) mod 8, wrapping 7→0.
  - rdy timing is unchanged (after 8 returns).
  - WB order is unaffected.
- Undefined: fill order is always offset 0..7.

Test Plan:
- Fill, in-order: miss_req with miss_addr=0x1236, memory latency 4 -> mem_addr reads 0x1230, 0x1232 … 0x123E on 8 consecutive cycles; cache_we at offsets 0..7 carrying the returned data; one rdy pulse 1 cycle after the 8th valid.
- Writeback then fill: wb_req with wb_addr=0xA0F0, cache_rdata = 0x1000+offset -> 8 writes at 0xA0F0..0xA0FE with data 0x1000..0x1007 and rdy pulse; controller then raises miss_req -> fill begins next IDLE cycle.
- Priority: wb_req=1 and miss_req=1 in the same cycle -> WB entered, mem_wr=1 on the first issue.
- Level request: miss_req held high through DONE -> exactly one fill, busy drops one cycle after rdy, no second mem_en burst while request low after that.
- Reset mid-fill: rst_n low after 3 returns -> all outputs 0 asynchronously; after release, new miss_req to 0x0040 restarts at offset 0 and receives all 8 words.
- Critical word first (macro defined): miss_addr=0x123C -> read order 0x123C, 0x123E, 0x1230 … 0x123A; cache_off sequence 6, 7, 0, 1, 2, 3, 4, 5.
